// File: rtl/depth_test_sink_pkg.sv
// Shared types for the depth-test sink: vertex depth formats, colour formats,
// and the sink's internal pipeline record plus framebuffer address helper.
package vertex_pkg;
  typedef logic [31:0] q16_16_t;
  typedef logic [15:0] depth16_t;
  localparam depth16_t ZBUF_FAR = 16'hFFFF;
  localparam q16_16_t  Q16_ONE  = 32'h0001_0000;
endpackage

package color_pkg;
  typedef logic [11:0] rgb444_t;
  localparam rgb444_t BG_COLOR_DEFAULT = 12'h000;
endpackage

package depth_test_sink_pkg;
  import vertex_pkg::*;
  import color_pkg::*;

  localparam int ADDR_W = 15;

  // Pixel as carried from the accept stage into the compare stage.
  typedef struct packed {
    logic              ok;     // in range and depth in [0,1)
    logic [ADDR_W-1:0] addr;
    depth16_t          z;
    logic [7:0]        x;
    logic [6:0]        y;
    rgb444_t           color;
  } pix_t;

  // y*width + x as a shift-add over the set bits of the (constant) width;
  // for 160 this reduces to (y<<7)+(y<<5)+x, so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x,
                                                input logic [6:0] y,
                                                input int unsigned width);
    logic [ADDR_W-1:0] acc;
    acc = ADDR_W'(x);
    for (int i = 0; i < ADDR_W; i++)
      if (width[i]) acc = acc + (ADDR_W'(y) << i);
    return acc;
  endfunction
endpackage

// File: rtl/depth_test_sink_zbuffer_ram.sv
// Z-buffer storage: simple dual-port, one clock, registered read.
// A read to the address being written returns the previous contents.
module zbuffer_ram #(
  parameter int DEPTH = 19200,
  parameter int AW    = 15,
  parameter int DW    = 16
) (
  input  logic          clk_render,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  // Write port and registered read port share the clock.
  always_ff @(posedge clk_render) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/depth_test_sink.sv
// Depth-test sink: clears z-buffer and framebuffer at frame start, then
// depth-tests rasterizer pixels (accept -> compare/write -> fb output).
module depth_test_sink
  import vertex_pkg::*;
  import color_pkg::*;
  import depth_test_sink_pkg::*;
#(
  parameter int      FB_WIDTH  = 160,
  parameter int      FB_HEIGHT = 120,
  parameter rgb444_t BG_COLOR  = BG_COLOR_DEFAULT
) (
  input  logic        clk_render,
  input  logic        btn_rst_n,
  input  logic        begin_frame,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [31:0] in_depth,
  input  logic [11:0] in_color,
  output logic        fb_we,
  output logic [7:0]  fb_x,
  output logic [6:0]  fb_y,
  output logic [11:0] fb_data,
  output logic        clearing,
  output logic [15:0] px_written,
  output logic [15:0] px_rejected
);
  localparam int NPIX = FB_WIDTH * FB_HEIGHT;
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [1:0]        rst_sync;
  logic              rst_n;
  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_addr;
  logic [7:0]        clr_x;
  logic [6:0]        clr_y;
  logic              clr_we, accept, in_ok;
  logic [ADDR_W-1:0] in_addr;
  logic              s1_vld;
  pix_t              s1;
  depth16_t          rd_z, z_old;
  logic              fwd_vld;
  logic [ADDR_W-1:0] fwd_addr;
  depth16_t          fwd_z;
  logic              pass, fail, z_we;
  logic [ADDR_W-1:0] z_waddr;
  depth16_t          z_wdata;

  // Reset asserts immediately, releases two clocks after the button does.
  always_ff @(posedge clk_render or negedge btn_rst_n) begin
    if (!btn_rst_n) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign in_ready = (state == S_RUN);
  assign clearing = (state == S_CLEAR);
  assign accept   = in_valid && in_ready;
  assign in_addr  = fb_addr(in_x, in_y, FB_WIDTH);
  assign in_ok    = (in_x < 8'(FB_WIDTH)) && (in_y < 7'(FB_HEIGHT)) &&
                    !in_depth[31] && (in_depth < Q16_ONE);

  // Clear sweep in raster order; begin_frame restarts it from anywhere.
  always_ff @(posedge clk_render or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR; clr_addr <= '0; clr_x <= '0; clr_y <= '0;
    end else if (begin_frame) begin
      state <= S_CLEAR; clr_addr <= '0; clr_x <= '0; clr_y <= '0;
    end else if (state == S_CLEAR) begin
      if (clr_addr == ADDR_W'(NPIX - 1)) state <= S_RUN;
      clr_addr <= clr_addr + 1'b1;
      if (clr_x == 8'(FB_WIDTH - 1)) begin
        clr_x <= '0;
        clr_y <= clr_y + 1'b1;
      end else begin
        clr_x <= clr_x + 1'b1;
      end
    end
  end

  // Accept stage: capture the pixel; z read is issued in the same cycle.
  always_ff @(posedge clk_render or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1     <= '0;
    end else begin
      s1_vld <= accept && !begin_frame;
      if (accept) s1 <= '{ok: in_ok, addr: in_ok ? in_addr : '0, z: in_depth[15:0],
                          x: in_x, y: in_y, color: in_color};
    end
  end

  // The RAM returns pre-write data when the previous pixel writes the
  // address this one reads, so that single write is forwarded here.
  assign z_old = (fwd_vld && fwd_addr == s1.addr) ? fwd_z : rd_z;
  assign pass  = s1_vld && !begin_frame && s1.ok && (s1.z < z_old);
  assign fail  = s1_vld && !begin_frame && !(s1.ok && (s1.z < z_old));

  // Clear and pixel writes never overlap: pixels only enter in RUN and a
  // begin_frame kills whatever is in the compare stage.
  assign clr_we  = (state == S_CLEAR) && !begin_frame;
  assign z_we    = clr_we || pass;
  assign z_waddr = clr_we ? clr_addr : s1.addr;
  assign z_wdata = clr_we ? ZBUF_FAR : s1.z;

  zbuffer_ram #(.DEPTH(NPIX), .AW(ADDR_W), .DW(16)) u_zbuf (
    .clk_render (clk_render),
    .we         (z_we),
    .waddr      (z_waddr),
    .wdata      (z_wdata),
    .raddr      (in_ok ? in_addr : '0),
    .rdata      (rd_z)
  );

  // Remember the last pixel z write for the forwarding compare.
  always_ff @(posedge clk_render or negedge rst_n) begin
    if (!rst_n) begin
      fwd_vld <= 1'b0; fwd_addr <= '0; fwd_z <= '0;
    end else begin
      fwd_vld <= pass; fwd_addr <= s1.addr; fwd_z <= s1.z;
    end
  end

  // Registered framebuffer port: clear writes at +1, pixel writes at +2.
  always_ff @(posedge clk_render or negedge rst_n) begin
    if (!rst_n) begin
      fb_we <= 1'b0; fb_x <= '0; fb_y <= '0; fb_data <= '0;
    end else begin
      fb_we <= z_we;
      if (clr_we) begin
        fb_x <= clr_x; fb_y <= clr_y; fb_data <= BG_COLOR;
      end else if (pass) begin
        fb_x <= s1.x; fb_y <= s1.y; fb_data <= s1.color;
      end
    end
  end

  // Per-frame saturating pass/reject counters.
  always_ff @(posedge clk_render or negedge rst_n) begin
    if (!rst_n) begin
      px_written <= '0; px_rejected <= '0;
    end else if (begin_frame) begin
      px_written <= '0; px_rejected <= '0;
    end else begin
      if (pass && !(&px_written))  px_written  <= px_written + 1'b1;
      if (fail && !(&px_rejected)) px_rejected <= px_rejected + 1'b1;
    end
  end
endmodule
